// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-ported register file and its scoreboard.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    typedef logic [$clog2(DEF_NREGS)-1:0] reg_addr_t;
    typedef logic [DEF_XLEN-1:0]          reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_pend_ctr.sv
// Per-register pending-write counter: saturating up/down, flags full/nonzero/underflow.
module regfile_pend_ctr #(
    parameter int PEND_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic nonzero,
    output logic underflow
);

    logic [PEND_W-1:0] cnt;

    assign full      = &cnt;
    assign nonzero   = |cnt;
    // A writeback with nothing outstanding is a stray producer, even if a new reservation lands.
    assign underflow = dec && !nonzero;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && nonzero) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-ported register file with x0 hardwired to zero, optional write->read bypass,
// and an integrated pending-write scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int PEND_W = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]    rd_busy_o,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic              rsv_en_i,
    input  logic [AW-1:0]     rsv_addr_i,
    output logic              rsv_ready_o,
    output logic              err_o
);

    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] rsv_inc;
    logic [NREGS-1:0] full;
    logic [NREGS-1:0] nonzero;
    logic [NREGS-1:0] underflow;

    // Per-register decrement: any enabled lane targeting r, counted once however many lanes hit.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_hit = '0;
        for (int r = 1; r < NREGS; r++) begin
            for (int l = 0; l < NWR; l++) begin
                if (wr_en_i[l] && wr_addr_i[l*AW +: AW] == AW'(r)) begin
                    wr_hit[r] = 1'b1;
                end
            end
        end
    end

    assign rsv_ready_o = (rsv_addr_i == ZERO) || !full[rsv_addr_i] || wr_hit[rsv_addr_i];

    always_comb begin
        rsv_inc = '0;
        if (rsv_en_i && rsv_ready_o && rsv_addr_i != ZERO) begin
            rsv_inc[rsv_addr_i] = 1'b1;
        end
    end

    assign full[0]      = 1'b0;
    assign nonzero[0]   = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_pend
        regfile_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (rsv_inc[r]),
            .dec       (wr_hit[r]),
            .full      (full[r]),
            .nonzero   (nonzero[r]),
            .underflow (underflow[r])
        );
    end

    // Later lanes overwrite earlier ones in this loop, so the highest lane wins a conflict.
    // NOTE: the array is reset explicitly because architectural state must read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int l = 0; l < NWR; l++) begin
                if (wr_en_i[l] && wr_addr_i[l*AW +: AW] != ZERO) begin
                    mem[wr_addr_i[l*AW +: AW]] <= wr_data_i[l*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (|underflow) begin
            err_o <= 1'b1;
        end
    end

    // Reads are forced to zero while reset is held so bypassed traffic cannot leak out.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rst_n && rd_addr_i[p*AW +: AW] != ZERO) begin
                rd_data_o[p*XLEN +: XLEN] = mem[rd_addr_i[p*AW +: AW]];
                rd_busy_o[p]              = nonzero[rd_addr_i[p*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int l = 0; l < NWR; l++) begin
                        if (wr_en_i[l] && wr_addr_i[l*AW +: AW] == rd_addr_i[p*AW +: AW]) begin
                            rd_data_o[p*XLEN +: XLEN] = wr_data_i[l*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a bypassing and a non-bypassing instance share stimulus and are
// checked every cycle against an array/counter model, plus directed literal checks.
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int XL = 32;
    localparam int NR = 32;
    localparam int A  = 5;
    localparam int MAXC = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2*A-1:0]  rd_addr;
    logic [2*XL-1:0] rd_data_b, rd_data_n;
    logic [1:0]      busy_b, busy_n;
    logic [1:0]      wr_en;
    logic [2*A-1:0]  wr_addr;
    logic [2*XL-1:0] wr_data;
    logic            rsv_en;
    logic [A-1:0]    rsv_addr;
    logic            ready_b, ready_n, err_b, err_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_mp_sb #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(1), .PEND_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(busy_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en),
        .rsv_addr_i(rsv_addr), .rsv_ready_o(ready_b), .err_o(err_b));

    regfile_mp_sb #(.XLEN(XL), .NREGS(NR), .NRD(2), .NWR(2), .BYPASS(0), .PEND_W(2)) dut_n (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(busy_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en),
        .rsv_addr_i(rsv_addr), .rsv_ready_o(ready_n), .err_o(err_n));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [XL-1:0] m_reg [NR];
    int            m_cnt [NR];
    bit            m_err;

    function automatic bit lane_hits(input int addr);
        for (int l = 0; l < 2; l++)
            if (wr_en[l] && int'(wr_addr[l*A +: A]) == addr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [XL-1:0] exp_data(input int p, input bit byp);
        int a;
        logic [XL-1:0] v;
        a = int'(rd_addr[p*A +: A]);
        if (!rst_n || a == 0) return '0;
        v = m_reg[a];
        if (byp)
            for (int l = 0; l < 2; l++)
                if (wr_en[l] && int'(wr_addr[l*A +: A]) == a) v = wr_data[l*XL +: XL];
        return v;
    endfunction

    function automatic bit exp_ready();
        int a;
        a = int'(rsv_addr);
        return (a == 0) || (m_cnt[a] < MAXC) || lane_hits(a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NR; r++) begin
                m_reg[r] = '0;
                m_cnt[r] = 0;
            end
            m_err = 1'b0;
        end else begin
            bit rdy;
            rdy = exp_ready();
            for (int r = 1; r < NR; r++) begin
                bit inc, dec;
                inc = rsv_en && rdy && int'(rsv_addr) == r;
                dec = lane_hits(r);
                if (dec && m_cnt[r] == 0) m_err = 1'b1;
                if (inc && !dec) m_cnt[r]++;
                else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
            end
            for (int l = 0; l < 2; l++)
                if (wr_en[l] && wr_addr[l*A +: A] != REG_ZERO)
                    m_reg[wr_addr[l*A +: A]] = wr_data[l*XL +: XL];
        end
    end

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            int a;
            a = int'(rd_addr[p*A +: A]);
            check($sformatf("data_byp[%0d]", p), 64'(rd_data_b[p*XL +: XL]), 64'(exp_data(p, 1'b1)));
            check($sformatf("data_nob[%0d]", p), 64'(rd_data_n[p*XL +: XL]), 64'(exp_data(p, 1'b0)));
            check($sformatf("busy_byp[%0d]", p), 64'(busy_b[p]), 64'(rst_n && a != 0 && m_cnt[a] != 0));
            check($sformatf("busy_nob[%0d]", p), 64'(busy_n[p]), 64'(rst_n && a != 0 && m_cnt[a] != 0));
        end
        check("ready_byp", 64'(ready_b), 64'(exp_ready()));
        check("ready_nob", 64'(ready_n), 64'(exp_ready()));
        check("err_byp", 64'(err_b), 64'(m_err));
        check("err_nob", 64'(err_n), 64'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        rsv_en = 1'b0;
    endtask

    task automatic wr(input int lane, input int addr, input logic [XL-1:0] data);
        wr_en[lane]            = 1'b1;
        wr_addr[lane*A +: A]   = A'(addr);
        wr_data[lane*XL +: XL] = data;
    endtask

    task automatic rsv(input int addr);
        rsv_en   = 1'b1;
        rsv_addr = A'(addr);
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {A'(a1), A'(a0)};
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        set_rd(0, 0);
        repeat (2) cyc();
        rst_n = 1'b1;

        // Reset asserted while traffic is active
        cyc(); rsv(3); wr(0, 6, 32'hAA); set_rd(6, 3);
        cyc();
        rst_n = 1'b0;
        #2;
        check("rst_data", 64'(rd_data_b[XL-1:0]), 64'h0);
        check("rst_busy", 64'(busy_b), 64'h0);
        check("rst_ready", 64'(ready_b), 64'h1);
        check("rst_err", 64'(err_b), 64'h0);
        cyc(); cyc();
        rst_n = 1'b1; idle();
        #2;
        check("post_rst_x6", 64'(rd_data_n[XL-1:0]), 64'h0);
        check("post_rst_busy_x3", 64'(busy_n[1]), 64'h0);

        // Bypass vs. array-only read, x0 write dropped
        cyc(); rsv(5); set_rd(5, 0);
        cyc(); idle(); wr(0, 5, 32'hDEADBEEF);
        #2;
        check("byp_same_cycle", 64'(rd_data_b[XL-1:0]), 64'hDEADBEEF);
        check("nob_same_cycle", 64'(rd_data_n[XL-1:0]), 64'h0);
        check("x5_busy", 64'(busy_b[0]), 64'h1);
        cyc(); idle();
        #2;
        check("nob_next_cycle", 64'(rd_data_n[XL-1:0]), 64'hDEADBEEF);
        check("x5_busy_clear", 64'(busy_b[0]), 64'h0);
        cyc(); wr(0, 0, 32'h1234); set_rd(0, 5);
        #2;
        check("x0_byp", 64'(rd_data_b[XL-1:0]), 64'h0);
        cyc(); idle();
        #2;
        check("x0_after", 64'(rd_data_n[XL-1:0]), 64'h0);

        // Two lanes hit x7 together
        cyc(); rsv(7);
        cyc(); rsv(7);
        cyc(); idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); set_rd(5, 7);
        #2;
        check("x7_byp_lane1", 64'(rd_data_b[2*XL-1:XL]), 64'h22);
        cyc(); idle();
        #2;
        check("x7_commit_lane1", 64'(rd_data_n[2*XL-1:XL]), 64'h22);
        check("x7_still_busy", 64'(busy_n[1]), 64'h1);
        cyc(); wr(0, 7, 32'h33);
        cyc(); idle();
        #2;
        check("x7_idle", 64'(busy_n[1]), 64'h0);

        // Saturate x3 and release one slot
        repeat (3) begin cyc(); idle(); rsv(3); end
        cyc(); rsv(3); set_rd(3, 0);
        #2;
        check("x3_full_ready", 64'(ready_b), 64'h0);
        check("x3_full_busy", 64'(busy_b[0]), 64'h1);
        cyc();
        #2;
        check("x3_held_ready", 64'(ready_n), 64'h0);
        cyc(); idle(); wr(0, 3, 32'h30);
        cyc(); idle(); rsv(3);
        #2;
        check("x3_ready_after_wr", 64'(ready_b), 64'h1);
        cyc(); idle();
        #2;
        check("x3_full_again", 64'(ready_b), 64'h0);
        repeat (3) begin cyc(); idle(); wr(0, 3, 32'h31); end
        cyc(); idle();
        #2;
        check("x3_drained", 64'(busy_b[0]), 64'h0);

        // Same-cycle reserve and writeback of x9
        cyc(); rsv(9); set_rd(9, 0);
        cyc(); rsv(9); wr(0, 9, 32'h99);
        #2;
        check("x9_busy_pre", 64'(busy_b[0]), 64'h1);
        cyc(); idle();
        #2;
        check("x9_busy_held", 64'(busy_b[0]), 64'h1);
        check("x9_data", 64'(rd_data_n[XL-1:0]), 64'h99);
        cyc(); wr(0, 9, 32'h0);
        cyc(); idle();
        #2;
        check("x9_idle", 64'(busy_b[0]), 64'h0);
        check("err_clean", 64'(err_b), 64'h0);

        // Unreserved writeback raises the sticky error
        cyc(); wr(0, 4, 32'h44); set_rd(4, 0);
        cyc(); idle();
        #2;
        check("err_set", 64'(err_b), 64'h1);
        check("x4_commit", 64'(rd_data_n[XL-1:0]), 64'h44);
        repeat (3) cyc();
        #2;
        check("err_sticky", 64'(err_n), 64'h1);
        cyc(); rst_n = 1'b0;
        #2;
        check("err_reset", 64'(err_b), 64'h0);
        cyc(); rst_n = 1'b1;
        cyc();
        #2;
        check("err_after_reset", 64'(err_n), 64'h0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
